// File: rtl/hilo_divider_pkg.sv
// ============================================================================
// Module  : hilo_divider_pkg
// Purpose : State encodings and sizing helpers shared by the HI/LO divider.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hilo_divider_pkg;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_PREP = 2'd1;
  localparam logic [1:0] DIV_ITER = 2'd2;
  localparam logic [1:0] DIV_FIX  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = DIV_IDLE,
    S_PREP = DIV_PREP,
    S_ITER = DIV_ITER,
    S_FIX  = DIV_FIX
  } div_state_t;

  // A 1-bit operand still needs a 1-bit counter.
  function automatic int div_count_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DIV_COUNT_W = div_count_w(32);

endpackage

`default_nettype wire

// File: rtl/hilo_divider_div_restore_step.sv
// ============================================================================
// Module  : div_restore_step
// Purpose : One combinational restoring-division iteration (shift, compare,
//           conditional subtract).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] w_shifted;
  logic           w_ge;

  assign w_shifted = {rem, q[WIDTH-1]};
  assign w_ge      = (w_shifted >= {1'b0, divisor});

  // True difference is below 2^WIDTH, so modular subtraction is exact.
  assign rem_next = w_ge ? (w_shifted[WIDTH-1:0] - divisor) : w_shifted[WIDTH-1:0];
  assign q_next   = {q[WIDTH-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/hilo_divider.sv
// ============================================================================
// Module  : hilo_divider
// Purpose : Iterative signed/unsigned divider owning the HI (remainder) and
//           LO (quotient) registers; one quotient bit per cycle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_divider
  import hilo_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int                   c_count_w = div_count_w(WIDTH);
  localparam logic [c_count_w-1:0] c_last    = c_count_w'(WIDTH - 1);

  div_state_t           r_state, w_state_next;
  logic [c_count_w-1:0] r_count;
  logic [WIDTH-1:0]     r_a, r_b, r_bmag, r_rem, r_q, r_hi, r_lo;
  logic                 r_signed, r_qneg, r_rneg, r_zero, r_done, r_dbz;
  logic [WIDTH-1:0]     w_rem_next, w_q_next, w_quot, w_remd;
  logic                 w_a_neg, w_b_neg;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_rem),
    .q        (r_q),
    .divisor  (r_bmag),
    .rem_next (w_rem_next),
    .q_next   (w_q_next)
  );

  assign w_a_neg = r_signed & r_a[WIDTH-1];
  assign w_b_neg = r_signed & r_b[WIDTH-1];
  assign w_quot  = r_qneg ? (~r_q + 1'b1)   : r_q;
  assign w_remd  = r_rneg ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_next = S_PREP;
      S_PREP:  w_state_next = (r_b == '0) ? S_FIX : S_ITER;
      S_ITER:  if (r_count == c_last) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_bmag   <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_signed <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: if (Start) begin
          r_a      <= Dividend;
          r_b      <= Divisor;
          r_signed <= Signed;
          r_zero   <= 1'b0;
          r_dbz    <= 1'b0;
        end
        S_PREP: begin
          if (r_b == '0) begin
            r_zero <= 1'b1;
          end else begin
            // Magnitudes wrap mod 2^WIDTH, so the most negative value stays as-is.
            r_q    <= w_a_neg ? (~r_a + 1'b1) : r_a;
            r_bmag <= w_b_neg ? (~r_b + 1'b1) : r_b;
            r_qneg <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            r_rem  <= '0;
            r_count <= '0;
          end
        end
        S_ITER: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          if (r_count != c_last) r_count <= r_count + 1'b1;
        end
        S_FIX: begin
          if (r_zero) begin
            r_lo  <= '1;
            r_hi  <= r_a;
            r_dbz <= 1'b1;
          end else begin
            r_lo <= w_quot;
            r_hi <= w_remd;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy      = (r_state != S_IDLE);
  assign Done      = r_done;
  assign DivByZero = r_dbz;
  assign Hi        = r_hi;
  assign Lo        = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_divider.sv
// ============================================================================
// Module  : tb_hilo_divider
// Purpose : Directed self-checking bench for the HI/LO divider.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_divider;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] Dividend = '0;
  logic [31:0] Divisor = '0;
  logic        Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;

  int compared = 0;
  int mismatched = 0;
  int ecount = 0;
  int t0 = 0;

  hilo_divider #(.WIDTH(32)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Signed    (Signed),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) ecount <= ecount + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a request now, lets edge 0 accept it, then checks the accept state.
  task automatic start_div(input string tag, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi_before, lo_before;
    hi_before = Hi;
    lo_before = Lo;
    Signed = sgn; Dividend = a; Divisor = b; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    Dividend = 32'hDEAD_BEEF; Divisor = 32'h0000_0003;
    t0 = ecount;
    check({tag, " busy_after_accept"}, {31'd0, Busy}, 32'd1);
    check({tag, " dbz_cleared"}, {31'd0, DivByZero}, 32'd0);
    check({tag, " hi_held"}, Hi, hi_before);
    check({tag, " lo_held"}, Lo, lo_before);
  endtask

  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input logic exp_dbz);
    logic gap;
    gap = 1'b0;
    while (!Done && (ecount - t0) < 60) begin
      if (!Busy) gap = 1'b1;
      @(posedge Clock); #1;
    end
    check({tag, " latency"}, ecount - t0, exp_lat);
    check({tag, " busy_continuous"}, {31'd0, gap}, 32'd0);
    check({tag, " done"}, {31'd0, Done}, 32'd1);
    check({tag, " busy_at_done"}, {31'd0, Busy}, 32'd0);
    check({tag, " lo"}, Lo, exp_lo);
    check({tag, " hi"}, Hi, exp_hi);
    check({tag, " dbz"}, {31'd0, DivByZero}, {31'd0, exp_dbz});
  endtask

  initial begin
    repeat (3) @(posedge Clock);
    #1;
    check("reset busy", {31'd0, Busy}, 32'd0);
    check("reset done", {31'd0, Done}, 32'd0);
    check("reset dbz", {31'd0, DivByZero}, 32'd0);
    check("reset hi", Hi, 32'd0);
    check("reset lo", Lo, 32'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    start_div("u100/7", 1'b0, 32'd100, 32'd7);
    wait_done("u100/7", 34, 32'd14, 32'd2, 1'b0);
    @(posedge Clock); #1;
    check("done_one_cycle", {31'd0, Done}, 32'd0);

    start_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done("s-7/2", 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

    start_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done("s7/-2", 34, 32'hFFFF_FFFD, 32'd1, 1'b0);

    start_div("div0", 1'b0, 32'h0000_1234, 32'd0);
    wait_done("div0", 2, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    @(posedge Clock); #1;
    check("dbz_held", {31'd0, DivByZero}, 32'd1);

    start_div("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("smin/-1", 34, 32'h8000_0000, 32'd0, 1'b0);

    start_div("umax/1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done("umax/1", 34, 32'hFFFF_FFFF, 32'd0, 1'b0);

    start_div("u50/5", 1'b0, 32'd50, 32'd5);
    repeat (9) @(posedge Clock);
    #1;
    Signed = 1'b0; Dividend = 32'd9; Divisor = 32'd3; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    wait_done("u50/5", 34, 32'd10, 32'd0, 1'b0);

    // Back-to-back request raised while Done is high.
    start_div("b2b100/7", 1'b0, 32'd100, 32'd7);
    wait_done("b2b100/7", 34, 32'd14, 32'd2, 1'b0);

    start_div("rst100/7", 1'b0, 32'd100, 32'd7);
    repeat (11) @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    check("async busy", {31'd0, Busy}, 32'd0);
    check("async done", {31'd0, Done}, 32'd0);
    check("async hi", Hi, 32'd0);
    check("async lo", Lo, 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
    start_div("post100/7", 1'b0, 32'd100, 32'd7);
    wait_done("post100/7", 34, 32'd14, 32'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
